// File: rtl/mod_seq_if.sv
// ============================================================================
//  Module   : mod_seq_if
//  Brief    : Start/busy/done handshake and operand/result bundle for mod_seq.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface mod_seq_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             div_zero;

    modport master (
        output start, a, n,
        input  busy, done, Q, R, div_zero
    );

    modport slave (
        input  start, a, n,
        output busy, done, Q, R, div_zero
    );
endinterface

`default_nettype wire

// File: rtl/mod_seq.sv
// ============================================================================
//  Module   : mod_seq
//  Brief    : Multi-cycle restoring divider, Q = a / n and R = a % n, with
//             BITS_PER_CYCLE quotient bits per clock and divide-by-zero flag.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mod_seq #(
    parameter int WIDTH          = 256,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    mod_seq_if.slave  bus
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [CNT_W-1:0] c_steps = CNT_W'(STEPS);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_p_next;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_t;
    logic             w_accept;

    // The restored partial remainder is always < n, so it fits in WIDTH bits;
    // only the shifted trial value needs the extra bit, which keeps MSB-set
    // divisors exact.
    always_comb begin
        w_a_next = a_q;
        w_p_next = p_q;
        w_sh     = '0;
        w_t      = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_sh     = {w_p_next, w_a_next[WIDTH-1]};
            w_t      = w_sh - {1'b0, n_q};
            w_a_next = {w_a_next[WIDTH-2:0], ~w_t[WIDTH]};
            w_p_next = w_t[WIDTH] ? w_sh[WIDTH-1:0] : w_t[WIDTH-1:0];
        end
    end

    assign w_accept = bus.start && (state_q != c_run);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        n_d     = n_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            c_run: begin
                a_d   = w_a_next;
                p_d   = w_p_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = c_done;
                    q_d     = w_a_next;
                    r_d     = w_p_next;
                    dz_d    = 1'b0;
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation, giving back-to-back issue.
                if (w_accept) begin
                    a_d   = bus.a;
                    n_d   = bus.n;
                    p_d   = '0;
                    cnt_d = c_steps;
                    if (bus.n == '0) begin
                        state_d = c_done;
                        q_d     = '1;
                        r_d     = bus.a;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = c_run;
                    end
                end else begin
                    state_d = c_idle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= c_idle;
            a_q     <= '0;
            n_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            n_q     <= n_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy     = (state_q == c_run);
    assign bus.done     = (state_q == c_done);
    assign bus.Q        = q_q;
    assign bus.R        = r_q;
    assign bus.div_zero = dz_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_seq.sv
// ============================================================================
//  Module   : tb_mod_seq
//  Brief    : Directed and randomised self-checking bench for mod_seq.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mod_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mod_seq_if #(.WIDTH(8))   if0 ();
    mod_seq_if #(.WIDTH(8))   if1 ();
    mod_seq_if #(.WIDTH(256)) if2 ();

    mod_seq #(.WIDTH(8),   .BITS_PER_CYCLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mod_seq #(.WIDTH(8),   .BITS_PER_CYCLE(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mod_seq #(.WIDTH(256), .BITS_PER_CYCLE(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int w);
        case (w)
            0:       return if0.done;
            1:       return if1.done;
            default: return if2.done;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic [255:0] get_q(input int w);
        case (w)
            0:       return 256'(if0.Q);
            1:       return 256'(if1.Q);
            default: return if2.Q;
        endcase
    endfunction

    function automatic logic [255:0] get_r(input int w);
        case (w)
            0:       return 256'(if0.R);
            1:       return 256'(if1.R);
            default: return if2.R;
        endcase
    endfunction

    function automatic logic get_dz(input int w);
        case (w)
            0:       return if0.div_zero;
            1:       return if1.div_zero;
            default: return if2.div_zero;
        endcase
    endfunction

    task automatic drive(input int w, input logic s, input logic [255:0] a, input logic [255:0] n);
        case (w)
            0:       begin if0.start = s; if0.a = a[7:0]; if0.n = n[7:0]; end
            1:       begin if1.start = s; if1.a = a[7:0]; if1.n = n[7:0]; end
            default: begin if2.start = s; if2.a = a;      if2.n = n;      end
        endcase
    endtask

    // One start pulse, bounded wait for done, then check results, latency and done width.
    task automatic op_exp(input int w, input string tag, input logic [255:0] a, input logic [255:0] n,
                          input logic [255:0] eq, input logic [255:0] er, input logic edz, input int elat);
        int lat;
        @(negedge clk);
        drive(w, 1'b1, a, n);
        @(negedge clk);
        drive(w, 1'b0, a, n);
        lat = 1;
        while (!get_done(w) && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 256'(lat), 256'(elat));
        chk({tag, "_busy_at_done"}, 256'(get_busy(w)), 256'(0));
        chk({tag, "_Q"}, get_q(w), eq);
        chk({tag, "_R"}, get_r(w), er);
        chk({tag, "_div_zero"}, 256'(get_dz(w)), 256'(edz));
        @(negedge clk);
        chk({tag, "_done_width"}, 256'(get_done(w)), 256'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        int bcnt;
        logic seen;
        logic [255:0] a256;
        logic [255:0] n256;
        logic [7:0] ra;
        logic [7:0] rn;

        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        drive(2, 1'b0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(if0.busy), 256'(0));
        chk("rst_done", 256'(if0.done), 256'(0));
        chk("rst_Q", 256'(if0.Q), 256'(0));
        chk("rst_R", 256'(if0.R), 256'(0));
        chk("rst_dz", 256'(if0.div_zero), 256'(0));
        rst_n = 1'b1;

        // 100/7 with busy-cycle count
        @(negedge clk);
        drive(0, 1'b1, 100, 7);
        @(negedge clk);
        drive(0, 1'b0, 100, 7);
        lat = 1;
        bcnt = 0;
        while (!if0.done && lat < 600) begin
            if (if0.busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk("d100_7_busy_cycles", 256'(bcnt), 256'(8));
        chk("d100_7_latency", 256'(lat), 256'(9));
        chk("d100_7_Q", 256'(if0.Q), 256'(14));
        chk("d100_7_R", 256'(if0.R), 256'(2));
        chk("d100_7_dz", 256'(if0.div_zero), 256'(0));

        op_exp(0, "d255_200", 255, 200, 1, 55, 1'b0, 9);
        op_exp(0, "d255_255", 255, 255, 1, 0,  1'b0, 9);
        op_exp(0, "d5_9",     5,   9,   0, 5,  1'b0, 9);
        op_exp(0, "d77_0",    77,  0,   8'hFF, 77, 1'b1, 1);

        // Reset at RUN cycle 4 aborts the operation
        @(negedge clk);
        drive(0, 1'b1, 100, 7);
        @(negedge clk);
        drive(0, 1'b0, 100, 7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (if0.done) seen = 1'b1;
        end
        chk("midrst_no_done", 256'(seen), 256'(0));
        chk("midrst_busy", 256'(if0.busy), 256'(0));
        chk("midrst_Q", 256'(if0.Q), 256'(0));
        chk("midrst_R", 256'(if0.R), 256'(0));
        chk("midrst_dz", 256'(if0.div_zero), 256'(0));

        op_exp(0, "d9_3", 9, 3, 3, 0, 1'b0, 9);

        // start pulsed mid-RUN is ignored
        @(negedge clk);
        drive(0, 1'b1, 200, 13);
        @(negedge clk);
        drive(0, 1'b0, 200, 13);
        lat = 1;
        while (!if0.done && lat < 600) begin
            if (lat == 3) drive(0, 1'b1, 1, 1);
            else          drive(0, 1'b0, 1, 1);
            @(negedge clk);
            lat++;
        end
        chk("ign_latency", 256'(lat), 256'(9));
        chk("ign_Q", 256'(if0.Q), 256'(15));
        chk("ign_R", 256'(if0.R), 256'(5));
        @(negedge clk);
        chk("ign_no_restart", 256'(if0.busy), 256'(0));

        // start held high through DONE: back-to-back operation
        drive(0, 1'b1, 100, 7);
        @(negedge clk);
        lat = 1;
        while (!if0.done && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b1_latency", 256'(lat), 256'(9));
        chk("b2b1_Q", 256'(if0.Q), 256'(14));
        chk("b2b1_R", 256'(if0.R), 256'(2));
        drive(0, 1'b1, 50, 6);
        @(negedge clk);
        drive(0, 1'b0, 50, 6);
        chk("b2b2_busy", 256'(if0.busy), 256'(1));
        lat = 1;
        while (!if0.done && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b2_latency", 256'(lat), 256'(9));
        chk("b2b2_Q", 256'(if0.Q), 256'(8));
        chk("b2b2_R", 256'(if0.R), 256'(2));

        // Two quotient bits per cycle
        op_exp(1, "k2_200_13", 200, 13, 15, 5, 1'b0, 5);

        // Full-width operands against the built-in wide arithmetic
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) begin
                a256[j*32 +: 32] = $urandom;
                n256[j*32 +: 32] = $urandom;
            end
            if (k == 1) n256 = n256 >> $urandom_range(1, 200);
            if (k == 2) n256[255] = 1'b1;
            if (n256 == '0) n256 = 256'd3;
            op_exp(2, "w256", a256, n256, a256 / n256, a256 % n256, 1'b0, 257);
        end

        // Random sweep with gaps, including divide-by-zero
        for (int k = 0; k < 300; k++) begin
            ra = 8'($urandom_range(0, 255));
            rn = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (rn == 8'd0)
                op_exp(0, "rnd_dz", 256'(ra), 0, 256'(8'hFF), 256'(ra), 1'b1, 1);
            else
                op_exp(0, "rnd", 256'(ra), 256'(rn), 256'(ra / rn), 256'(ra % rn), 1'b0, 9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
